// File: rtl/sub_ctrl_pkg.sv
// Shared constants for the serial subtractor sequencer: FSM state encoding
// and the default operand width.
package sub_ctrl_pkg;

    localparam int SUB_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: d = x - y - z, b = borrow out of the stage.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic d,
    output logic b
);

    assign d = x ^ y ^ z;
    assign b = (~x & y) | (~(x ^ y) & z);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full_sub cell stepped LSB first,
// with valid/ready handshakes on both the operand and the result side.
module serial_sub_ctrl
    import sub_ctrl_pkg::*;
#(
    parameter int WIDTH = SUB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               borrow;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   diff_sr;
    logic [WIDTH-1:0]   diff_next;
    logic               cell_d;
    logic               cell_b;
    logic               last_step;

    full_sub u_cell (
        .x (a_sr[0]),
        .y (b_sr[0]),
        .z (borrow),
        .d (cell_d),
        .b (cell_b)
    );

    // Result bits enter at the MSB so that after WIDTH steps the LSB lands at bit 0.
    generate
        if (WIDTH == 1) begin : g_w1
            assign diff_next = cell_d;
        end else begin : g_wn
            assign diff_next = {cell_d, diff_sr[WIDTH-1:1]};
        end
    endgenerate

    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        busy        = 1'b1;
        case (state)
            ST_IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_step) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            borrow     <= 1'b0;
            a_sr       <= '0;
            b_sr       <= '0;
            diff_sr    <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= borrow_in;
                        cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= diff_next;
                    borrow  <= cell_b;
                    cnt     <= cnt + CNT_W'(1);
                    if (last_step) begin
                        diff       <= diff_next;
                        borrow_out <= cell_b;
                        zero       <= (diff_next == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random checks of serial_sub_ctrl at WIDTH=8.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         done_valid;
    logic         done_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         zero;
    logic         busy;

    int vectors    = 0;
    int miscompares = 0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .borrow_in   (borrow_in),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .diff        (diff),
        .borrow_out  (borrow_out),
        .zero        (zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for the result, stall, then complete the result handshake.
    task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input logic op_bin, input int stall,
                         output logic [W-1:0] got_diff, output logic got_bout,
                         output logic got_zero, output int lat, output logic timeout);
        int guard;
        timeout = 1'b0;
        guard = 0;
        while (!start_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!start_ready) timeout = 1'b1;
        a = op_a;
        b = op_b;
        borrow_in = op_bin;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        a = ~op_a;
        b = ~op_b;
        borrow_in = ~op_bin;
        lat = 0;
        while (!done_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!done_valid) timeout = 1'b1;
        got_diff = diff;
        got_bout = borrow_out;
        got_zero = zero;
        for (int i = 0; i < stall; i++) tick();
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if ({start_ready, done_valid, busy} !== 3'b100) begin
            $display("FAIL reset_ctrl: got %b want 100", {start_ready, done_valid, busy});
            miscompares++;
        end
        vectors++;
        if ({borrow_out, zero, diff} !== 10'd0) begin
            $display("FAIL reset_data: got %h want 000", {borrow_out, zero, diff});
            miscompares++;
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] va [4] = '{8'h05, 8'h03, 8'h00, 8'h5A};
        logic [W-1:0] vb [4] = '{8'h03, 8'h05, 8'h00, 8'h5A};
        logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] ed [4] = '{8'h02, 8'hFE, 8'hFF, 8'h00};
        logic         eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic         ez [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] gd;
        logic gb, gz, to;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vc[i], 0, gd, gb, gz, lat, to);
            vectors++;
            if (to || lat != W) begin
                $display("FAIL basic_latency[%0d]: got %0d timeout=%b want %0d", i, lat, to, W);
                miscompares++;
            end
            vectors++;
            if ({gb, gz, gd} !== {eb[i], ez[i], ed[i]}) begin
                $display("FAIL basic_result[%0d]: got bo=%b z=%b d=%h want bo=%b z=%b d=%h",
                         i, gb, gz, gd, eb[i], ez[i], ed[i]);
                miscompares++;
            end
            vectors++;
            if ({start_ready, done_valid, busy} !== 3'b100) begin
                $display("FAIL basic_idle[%0d]: got %b want 100", i, {start_ready, done_valid, busy});
                miscompares++;
            end
        end
    endtask

    task automatic test_backpressure();
        int guard = 0;
        a = 8'hA0;
        b = 8'h0F;
        borrow_in = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        while (!done_valid && guard < 100) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            a = 8'hFF;
            b = 8'h00;
            borrow_in = 1'b1;
            start_valid = 1'b1;
            tick();
            vectors++;
            if ({done_valid, start_ready, borrow_out, zero, diff} !== {4'b1000, 8'h91}) begin
                $display("FAIL hold[%0d]: got dv=%b sr=%b bo=%b z=%b d=%h want dv=1 sr=0 bo=0 z=0 d=91",
                         i, done_valid, start_ready, borrow_out, zero, diff);
                miscompares++;
            end
        end
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        start_valid = 1'b0;
        vectors++;
        if ({start_ready, done_valid, busy, diff} !== {3'b100, 8'h91}) begin
            $display("FAIL release: got sr=%b dv=%b busy=%b d=%h want sr=1 dv=0 busy=0 d=91",
                     start_ready, done_valid, busy, diff);
            miscompares++;
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL no_b2b: got busy=%b want 0", busy);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] gd;
        logic gb, gz, to;
        int lat;
        a = 8'h33;
        b = 8'h11;
        borrow_in = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({start_ready, done_valid, busy, borrow_out, zero, diff} !== {5'b10000, 8'h00}) begin
            $display("FAIL mid_reset: got sr=%b dv=%b busy=%b bo=%b z=%b d=%h want sr=1 dv=0 busy=0 bo=0 z=0 d=00",
                     start_ready, done_valid, busy, borrow_out, zero, diff);
            miscompares++;
        end
        for (int i = 0; i < W + 2; i++) begin
            tick();
            vectors++;
            if (done_valid !== 1'b0) begin
                $display("FAIL mid_reset_pulse[%0d]: got dv=%b want 0", i, done_valid);
                miscompares++;
            end
        end
        do_op(8'h10, 8'h01, 1'b0, 2, gd, gb, gz, lat, to);
        vectors++;
        if (to || {gb, gz, gd} !== {2'b00, 8'h0F}) begin
            $display("FAIL after_reset: got bo=%b z=%b d=%h timeout=%b want bo=0 z=0 d=0f",
                     gb, gz, gd, to);
            miscompares++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, gd;
        logic rc, gb, gz, to;
        logic [W:0] exp;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            exp = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rc};
            do_op(ra, rb, rc, $urandom_range(0, 3), gd, gb, gz, lat, to);
            vectors++;
            if (to || {gb, gd} !== exp || gz !== (exp[W-1:0] == '0)) begin
                $display("FAIL random[%0d] %h-%h-%b: got bo=%b d=%h z=%b timeout=%b want bo=%b d=%h z=%b",
                         i, ra, rb, rc, gb, gd, gz, to, exp[W], exp[W-1:0], exp[W-1:0] == '0);
                miscompares++;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        start_valid = 1'b0;
        done_ready = 1'b0;
        a = '0;
        b = '0;
        borrow_in = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
